spike_dispatcher: RTL and testbench

SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

---
 rtl/snn_pkg.sv | 14 +
 rtl/spike_fifo.sv | 46 ++++
 rtl/spike_dispatcher.sv | 137 +++++++++++++
 tb/tb_spike_dispatcher.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spike dispatch path: address width, idle address
// and the dispatcher state encoding.
package snn_pkg;
  localparam int ADDR_W = 12;
  localparam logic [ADDR_W-1:0] IDLE_ADDR = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_GAP   = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } disp_state_e;
endpackage

// File: rtl/spike_fifo.sv
// Synchronous spike FIFO; pointers carry an extra wrap bit to tell full from empty.
module spike_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: emptiness is defined purely by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spike_dispatcher.sv
// Serialises buffered spike addresses onto the MAC address bus, separating
// each address with an idle gap, and closes each timestep with a clear strobe.
module spike_dispatcher #(
  parameter int                           DEPTH        = 16,
  parameter int                           HOLD_CYCLES  = 2,
  parameter int                           CLEAR_CYCLES = 2,
  parameter logic [snn_pkg::ADDR_W-1:0]   IDLE_ADDR    = snn_pkg::IDLE_ADDR
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         spike_valid,
  input  logic [snn_pkg::ADDR_W-1:0]   spike_addr,
  output logic                         spike_ready,
  input  logic                         timestep_end,
  output logic [snn_pkg::ADDR_W-1:0]   source_address,
  output logic                         clear,
  output logic                         done,
  output logic                         busy,
  output logic                         ts_err
);
  import snn_pkg::*;

  localparam int CNT_W = 16;

  disp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] cur_q, cur_d, src_q, src_d;
  logic              clear_q, clear_d, done_q, done_d;
  logic              pend_q, pend_d, err_q, err_d, en_q;
  logic              fifo_full, fifo_empty, push, pop;
  logic [ADDR_W-1:0] head;

  assign spike_ready    = en_q & ~fifo_full & ~pend_q;
  assign push           = spike_valid & spike_ready;
  assign source_address = src_q;
  assign clear          = clear_q;
  assign done           = done_q;
  assign ts_err         = err_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

  spike_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (spike_addr),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= IDLE_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  // GAP chains straight into the next DRIVE when work is queued so the bus
  // sustains one spike every HOLD_CYCLES+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end else if (pend_q && !done_q) begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = ST_GAP;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      ST_GAP: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) state_d = ST_DONE;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    src_d   = (state_q == ST_DRIVE) ? cur_q : IDLE_ADDR;
    clear_d = (state_q == ST_CLEAR);
    done_d  = (state_q == ST_DONE);
  end

  // Pending drops as the done pulse ends, so new spikes land in the next timestep.
  always_comb begin
    pend_d = pend_q;
    if (done_q) pend_d = 1'b0;
    if (timestep_end && !pend_q) pend_d = 1'b1;
    err_d = err_q | (timestep_end & pend_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_q   <= IDLE_ADDR;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      src_q   <= src_d;
      clear_q <= clear_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      en_q    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: bus timing, ordering, fill, timestep
// clear sequence, double-end error and asynchronous reset.
module tb_spike_dispatcher;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        spike_valid;
  logic [11:0] spike_addr;
  logic        spike_ready;
  logic        timestep_end;
  logic [11:0] source_address;
  logic        clear;
  logic        done;
  logic        busy;
  logic        ts_err;

  int tests = 0;
  int fails = 0;
  logic [11:0] cap_q[$];
  logic [11:0] prev_src;

  always #5 clock = ~clock;

  spike_dispatcher dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .spike_valid    (spike_valid),
    .spike_addr     (spike_addr),
    .spike_ready    (spike_ready),
    .timestep_end   (timestep_end),
    .source_address (source_address),
    .clear          (clear),
    .done           (done),
    .busy           (busy),
    .ts_err         (ts_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later; log each address at its first bus cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (source_address !== 12'hFFF && prev_src === 12'hFFF) cap_q.push_back(source_address);
    prev_src = source_address;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Expected per-edge values for the timestep test, edges E2..E12.
  logic [11:0] ts_src [11] = '{12'd13, 12'd13, 12'hFFF, 12'd16, 12'd16, 12'hFFF,
                               12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
  logic        ts_clr [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  logic        ts_don [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic        ts_rdy [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int n_clr, n_don, n_act;
    logic [11:0] bus_exp [9];
    reset_n = 1'b0; spike_valid = 1'b0; spike_addr = '0; timestep_end = 1'b0;
    prev_src = 12'hFFF;
    repeat (3) tick();

    // Reset state
    chk("rst_src", source_address, 12'hFFF);
    chk("rst_clear", clear, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ts_err", ts_err, 0);
    chk("rst_ready", spike_ready, 0);
    reset_n = 1'b1;
    tick();
    chk("ready_after_rst", spike_ready, 1);

    // Single spike: appears after E2, held 2 cycles, then one idle cycle
    spike_valid = 1'b1; spike_addr = 12'd13;
    tick();                                   // E0
    spike_valid = 1'b0;
    chk("single_busy", busy, 1);
    tick(); chk("single_e1", source_address, 12'hFFF);
    tick(); chk("single_e2", source_address, 12'd13);
    tick(); chk("single_e3", source_address, 12'd13);
    tick(); chk("single_e4", source_address, 12'hFFF);
    chk("single_idle", busy, 0);

    // Repeated address: push 14,14,15 back-to-back
    spike_valid = 1'b1; spike_addr = 12'd14; tick();   // E0
    spike_addr = 12'd14; tick();                        // E1 (push with pop)
    spike_addr = 12'd15; tick();                        // E2
    spike_valid = 1'b0;
    bus_exp = '{12'd14, 12'd14, 12'hFFF, 12'd14, 12'd14, 12'hFFF, 12'd15, 12'd15, 12'hFFF};
    chk("rep_bus0", source_address, bus_exp[0]);
    for (int i = 1; i < 9; i++) begin
      tick();
      chk($sformatf("rep_bus%0d", i), source_address, bus_exp[i]);
    end
    tick();
    chk("rep_idle", busy, 0);
    repeat (3) tick();

    // Fill: offers on every edge; FIFO reaches full after E23, 25th offer refused
    cap_q.delete();
    for (int i = 0; i < 25; i++) begin
      spike_valid = 1'b1; spike_addr = 12'(100 + i);
      tick();
      if (i == 22) chk("fill_ready_e22", spike_ready, 1);
      if (i == 23) chk("fill_full_e23", spike_ready, 0);
      if (i == 24) chk("fill_full_e24", spike_ready, 0);
    end
    spike_valid = 1'b0;
    for (int i = 0; i < 150 && (busy || source_address !== 12'hFFF); i++) tick();
    chk("fill_drained", busy, 0);
    chk("fill_count", cap_q.size(), 24);
    for (int i = 0; i < 24 && i < cap_q.size(); i++)
      chk($sformatf("fill_order%0d", i), cap_q[i], 12'(100 + i));
    repeat (3) tick();

    // Timestep: 16 pushed with timestep_end; held valid waits until after done
    spike_valid = 1'b1; spike_addr = 12'd13; tick();                 // E0
    spike_addr = 12'd16; timestep_end = 1'b1; tick();                 // E1
    timestep_end = 1'b0; spike_addr = 12'h055;
    chk("ts_ready_e1", spike_ready, 0);
    for (int i = 0; i < 11; i++) begin
      tick();                                                         // E2..E12
      chk($sformatf("ts_src_e%0d", i + 2), source_address, ts_src[i]);
      chk($sformatf("ts_clr_e%0d", i + 2), clear, ts_clr[i]);
      chk($sformatf("ts_done_e%0d", i + 2), done, ts_don[i]);
      chk($sformatf("ts_rdy_e%0d", i + 2), spike_ready, ts_rdy[i]);
    end
    tick();                                                           // E13 accept
    spike_valid = 1'b0;
    tick(); tick();
    chk("ts_next_spike", source_address, 12'h055);
    chk("ts_no_err", ts_err, 0);
    repeat (5) tick();
    chk("ts_idle", busy, 0);

    // Double timestep_end: error latched, only one clear sequence
    timestep_end = 1'b1; tick();                                      // E0
    tick();                                                           // E1
    timestep_end = 1'b0;
    chk("dbl_ts_err", ts_err, 1);
    n_clr = 0; n_don = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (clear) n_clr++;
      if (done) n_don++;
    end
    chk("dbl_clear_cycles", n_clr, 2);
    chk("dbl_done_pulses", n_don, 1);
    chk("dbl_err_sticky", ts_err, 1);
    chk("dbl_ready", spike_ready, 1);

    // Reset with queued spikes discards them
    spike_valid = 1'b1;
    spike_addr = 12'h031; tick();
    spike_addr = 12'h032; tick();
    spike_addr = 12'h033; tick();
    spike_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rstq_busy", busy, 0);
    chk("rstq_src", source_address, 12'hFFF);
    chk("rstq_err_cleared", ts_err, 0);
    tick();
    reset_n = 1'b1;
    tick();
    n_act = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (source_address !== 12'hFFF) n_act++;
    end
    chk("rstq_nothing_sent", n_act, 0);

    // Reset during CLEAR drops clear asynchronously
    timestep_end = 1'b1; tick();
    timestep_end = 1'b0;
    tick(); tick();
    chk("rstc_clear_high", clear, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstc_clear", clear, 0);
    chk("rstc_src", source_address, 12'hFFF);
    chk("rstc_busy", busy, 0);
    chk("rstc_ready", spike_ready, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rstc_ready_back", spike_ready, 1);
    spike_valid = 1'b1; spike_addr = 12'h044; tick();
    spike_valid = 1'b0;
    tick(); tick();
    chk("rstc_resume", source_address, 12'h044);
    chk("rstc_no_clear", clear, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
